ring_johnson_ctr: RTL and testbench
===================================

# ring_johnson_ctr

Parametrised shift-register counter that supports both ring (one-hot circulating) and Johnson (twisted-ring) sequences. It adds run-time mode and direction selection, enable, parallel load, a wrap pulse and illegal-state detection. It replaces the fixed 4-bit ring counter as the sequencing and phase-generation primitive in timing and stepper-style control paths.

## Interface

- `WIDTH`, default 4: number of counter bits; legal range 2..32.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: synchronous, active-high reset.
- `en` input, 1: advance one step per cycle when high.
- `mode` input, 1: 0 = ring, 1 = Johnson.
- `dir` input, 1: 0 = shift toward MSB (left), 1 = shift toward LSB (right).
- `load` input, 1: parallel load request.
- `load_val` input, WIDTH: value written on load.
- `out` output, WIDTH: counter state, registered.
- `wrap` output, 1: registered, one-cycle pulse when a step lands on the seed.
- `illegal` output, 1: combinational; `out` is not a legal state for the active mode.

## Operation

- **Seed:** ring seed = `{0…0,1}` (LSB set); Johnson seed = all zeros.
- **Internal register `mode_q`:** holds the active mode. It captures `mode` on reset, on mode change and on load.
- **Next-state priority, per cycle:** reset > load > mode change > step > hold.
- **Reset:** `out` = seed of the sampled `mode`, `mode_q` = `mode`, `wrap` = 0.
- **Load:** `out` = `load_val` verbatim (illegal values included), `mode_q` = `mode`, `wrap` = 0.
- **Mode change (`mode` != `mode_q`, no load):** `out` = seed of the new mode, `mode_q` updated, `wrap` = 0, no step that cycle.
- **Step (`en`=1, none of the above):**
  - ring left: `{out[W-2:0], out[W-1]}`
  - ring right: `{out[0], out[W-1:1]}`
  - Johnson left: `{out[W-2:0], ~out[W-1]}`
  - Johnson right: `{~out[0], out[W-1:1]}`
- **Hold:** with `en`=0 and no other event, `out` holds and `wrap` = 0.
- **`wrap`:** set to 1 exactly when a step produces a next `out` equal to the current mode's seed; otherwise 0.
- **Period:** ring = WIDTH steps; Johnson = 2·WIDTH steps, in either direction.
- **`dir` changes:** may change on any cycle and take effect on the next step with no reseed. The sequence reverses from the current state.
- **`illegal` in ring mode:** asserted when `out` is not exactly one-hot.
- **`illegal` in Johnson mode:** asserted when the number of positions i in 0..W-2 with `out[i]` != `out[i+1]` exceeds 1. Legal states are exactly 2·WIDTH patterns.
- **`illegal` evaluation:** always against `mode_q`, not the raw `mode` input.

## Timing

- All state updates occur on the rising `clk` edge; reset is synchronous, so it is ignored between edges.
- Reset values: `out` = seed (`0001` ring or `0000` Johnson at WIDTH=4), `wrap` = 0, `illegal` = 0.
- Step latency: 1 cycle from `en` sampled high to new `out`.
- `wrap` is coincident with the cycle in which `out` first shows the seed after a step.
- Load latency: 1 cycle; `illegal` reflects the loaded value in the same cycle `out` does.
- Reset asserted mid-sequence reseeds on the next edge regardless of `load`/`en`.
- Simultaneous `load` and `en`: load wins and no step occurs.
- Simultaneous mode change and `en`: reseed only.

## Configuration

- `RJC_SELF_CORRECT_EN` defined: when a step is requested while `illegal`=1, the next `out` is the seed instead of the shifted value. `wrap` pulses on that cycle. Recovery takes one step.
- `RJC_SELF_CORRECT_EN` undefined: illegal patterns shift normally per the mode equations and persist indefinitely. `illegal` still flags them.
- Both builds: load, reset and mode-change behaviour are identical.

## Test plan

All scenarios use WIDTH=4.

- **Ring left:** reset with `mode`=0, then `en`=1, `dir`=0 for 4 cycles -> `out` 0010, 0100, 1000, 0001; `wrap`=1 only on 0001.
- **Johnson left and right:** reset with `mode`=1, `dir`=0, 8 steps -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with `wrap` on the 8th step. Repeat with `dir`=1 -> 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- **Hold and direction flip:** in ring mode at 0100, `en`=0 for 3 cycles -> holds 0100, `wrap`=0. Then `dir`=1, `en`=1 -> 0010, 0001 (`wrap`=1), 1000.
- **Load and priority:** `load`=1, `en`=1, `load_val`=0101, ring mode -> `out`=0101 and `illegal`=1. Next step gives 1010 without the macro, or 0001 with `wrap`=1 with the macro.
- **Mode switch and reset mid-run:** Johnson at 0111, drive `mode`=0 with `en`=1 -> `out`=0001, no shift, `wrap`=0. A later `reset`=1 together with `load`=1 -> seed, `wrap`=0.

Source files
------------

// File: rtl/ring_johnson_ctr_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_johnson_ctr_if
// Description : Control and status bundle for ring_johnson_ctr.
//               master: drives en/mode/dir/load/load_val, observes
//                       out/wrap/illegal.
//               slave : the counter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_johnson_ctr_if #(
    parameter int WIDTH = 4
);
    logic             en;        // advance one step per cycle
    logic             mode;      // 0 = ring, 1 = Johnson
    logic             dir;       // 0 = toward MSB, 1 = toward LSB
    logic             load;      // parallel load request
    logic [WIDTH-1:0] load_val;  // value written on load
    logic [WIDTH-1:0] out;       // registered counter state
    logic             wrap;      // registered one-cycle pulse on landing at seed
    logic             illegal;   // combinational: out not legal for active mode

    modport master (
        output en, mode, dir, load, load_val,
        input  out, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output out, wrap, illegal
    );
endinterface
`default_nettype wire

// File: rtl/ring_johnson_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ring_johnson_ctr
// Description : Parametrised shift-register counter running either a ring
//               (one-hot circulating) or Johnson (twisted-ring) sequence,
//               with run-time mode/direction, enable, parallel load, a wrap
//               pulse and illegal-state detection.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high reset
//               bus   - ring_johnson_ctr_if.slave
//                       in : en, mode, dir, load, load_val[WIDTH-1:0]
//                       out: out[WIDTH-1:0] (reg), wrap (reg), illegal (comb)
// Parameters  : WIDTH - counter bits, legal range 2..32
// Macros      : RJC_SELF_CORRECT_EN - when defined, a step taken from an
//               illegal state reseeds instead of shifting (wrap pulses).
//               Undefined: illegal patterns shift normally and persist.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_johnson_ctr #(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ring_johnson_ctr_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic             C_MODE_RING    = 1'b0;
    localparam logic [WIDTH-1:0] C_RING_SEED    = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_JOHNSON_SEED = '0;
    localparam logic [WIDTH-1:0] C_ONE          = WIDTH'(1);
    localparam logic [WIDTH-2:0] C_T_ONE        = (WIDTH-1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_out;
    logic             r_mode_q;   // mode the current sequence belongs to
    logic             r_wrap;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_seed_new;   // seed of the incoming mode input
    logic [WIDTH-1:0] w_seed_cur;   // seed of the active (registered) mode
    logic [WIDTH-1:0] w_shift;      // plain shifted value for active mode/dir
    logic [WIDTH-1:0] w_step_val;   // value taken on a step
    logic [WIDTH-2:0] w_trans;      // adjacent-bit differences
    logic             w_ring_bad;
    logic             w_johnson_bad;
    logic             w_illegal;
    logic             w_mode_chg;

    assign w_seed_new = (bus.mode == C_MODE_RING) ? C_RING_SEED : C_JOHNSON_SEED;
    assign w_seed_cur = (r_mode_q == C_MODE_RING) ? C_RING_SEED : C_JOHNSON_SEED;
    assign w_mode_chg = (bus.mode != r_mode_q);

    always_comb begin
        w_shift = r_out;
        case ({r_mode_q, bus.dir})
            2'b00:   w_shift = {r_out[WIDTH-2:0], r_out[WIDTH-1]};    // ring left
            2'b01:   w_shift = {r_out[0], r_out[WIDTH-1:1]};          // ring right
            2'b10:   w_shift = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};   // Johnson left
            2'b11:   w_shift = {~r_out[0], r_out[WIDTH-1:1]};         // Johnson right
            default: w_shift = r_out;
        endcase
    end

    // Ring: legal iff exactly one bit set. x & (x-1) clears the lowest set
    // bit, so a non-zero result means two or more bits were set.
    assign w_ring_bad = (r_out == '0) || ((r_out & (r_out - C_ONE)) != '0);

    // Johnson: a legal pattern has at most one boundary between a run of
    // ones and a run of zeros. Same bit trick on the boundary vector.
    assign w_trans       = r_out[WIDTH-2:0] ^ r_out[WIDTH-1:1];
    assign w_johnson_bad = ((w_trans & (w_trans - C_T_ONE)) != '0);

    // Judged against the registered mode so a pending mode change on the
    // input does not disturb the flag for the state currently shown.
    assign w_illegal = (r_mode_q == C_MODE_RING) ? w_ring_bad : w_johnson_bad;

`ifdef RJC_SELF_CORRECT_EN
    assign w_step_val = w_illegal ? w_seed_cur : w_shift;
`else
    assign w_step_val = w_shift;
`endif

    // ------------------------------------------------------------------
    // Next-state: reset > load > mode change > step > hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= w_seed_new;
            r_mode_q <= bus.mode;
            r_wrap   <= 1'b0;
        end else if (bus.load) begin
            r_out    <= bus.load_val;
            r_mode_q <= bus.mode;
            r_wrap   <= 1'b0;
        end else if (w_mode_chg) begin
            // Reseed only; the step requested this cycle is dropped.
            r_out    <= w_seed_new;
            r_mode_q <= bus.mode;
            r_wrap   <= 1'b0;
        end else if (bus.en) begin
            r_out    <= w_step_val;
            r_wrap   <= (w_step_val == w_seed_cur);
        end else begin
            r_wrap   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out     = r_out;
    assign bus.wrap    = r_wrap;
    assign bus.illegal = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ring_johnson_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_johnson_ctr
// Description : Directed self-checking bench for ring_johnson_ctr, WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_johnson_ctr;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ring_johnson_ctr_if #(.WIDTH(WIDTH)) bus ();

    ring_johnson_ctr #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] o, input logic w, input logic il);
        chk({tag, ".out"},     {28'd0, bus.out}, {28'd0, o});
        chk({tag, ".wrap"},    {31'd0, bus.wrap}, {31'd0, w});
        chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, il});
    endtask

    logic [3:0] ring_l  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_l  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] john_r  [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] flip_r  [3] = '{4'b0010, 4'b0001, 4'b1000};
    logic       flip_w  [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // ---------------- reset, ring ----------------
        tick();
        chk_state("rst_ring", 4'b0001, 1'b0, 1'b0);
        reset = 1'b0;

        // ---------------- ring left ----------------
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_state($sformatf("ring_l%0d", i), ring_l[i], (i == 3), 1'b0);
        end
        bus.en = 1'b0;
        tick();
        chk_state("ring_hold_after_wrap", 4'b0001, 1'b0, 1'b0);

        // ---------------- Johnson left / right ----------------
        reset    = 1'b1;
        bus.mode = 1'b1;
        tick();
        chk_state("rst_john", 4'b0000, 1'b0, 1'b0);
        reset  = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_state($sformatf("john_l%0d", i), john_l[i], (i == 7), 1'b0);
        end
        bus.dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_state($sformatf("john_r%0d", i), john_r[i], (i == 7), 1'b0);
        end

        // ---------------- hold and direction flip ----------------
        bus.dir  = 1'b0;
        bus.mode = 1'b0;          // mode change with en=1: reseed only
        tick();
        chk_state("to_ring", 4'b0001, 1'b0, 1'b0);
        tick();
        tick();
        chk_state("ring_at_0100", 4'b0100, 1'b0, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("hold%0d", i), 4'b0100, 1'b0, 1'b0);
        end
        bus.dir = 1'b1;
        bus.en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("flip%0d", i), flip_r[i], flip_w[i], 1'b0);
        end

        // ---------------- load priority and illegal ----------------
        bus.load     = 1'b1;
        bus.load_val = 4'b0101;
        tick();
        chk_state("load_0101", 4'b0101, 1'b0, 1'b1);
        bus.load = 1'b0;
        tick();
`ifdef RJC_SELF_CORRECT_EN
        chk_state("step_illegal", 4'b0001, 1'b1, 1'b0);
`else
        chk_state("step_illegal", 4'b1010, 1'b0, 1'b1);
`endif
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'b0000;
        tick();
        chk_state("load_ring_zero", 4'b0000, 1'b0, 1'b1);
        bus.mode     = 1'b1;
        bus.load_val = 4'b0101;
        tick();
        chk_state("load_john_0101", 4'b0101, 1'b0, 1'b1);
        bus.load_val = 4'b1100;
        tick();
        chk_state("load_john_1100", 4'b1100, 1'b0, 1'b0);
        bus.load = 1'b0;

        // illegal tracks the registered mode, not the raw input
        bus.mode = 1'b0;
        #1;
        chk("illegal_uses_mode_q", {31'd0, bus.illegal}, 32'd0);
        tick();
        chk_state("reseed_ring", 4'b0001, 1'b0, 1'b0);

        // ---------------- mode switch and reset mid-run ----------------
        reset    = 1'b1;
        bus.mode = 1'b1;
        bus.dir  = 1'b0;
        tick();
        reset  = 1'b0;
        bus.en = 1'b1;
        tick();
        tick();
        tick();
        chk_state("john_0111", 4'b0111, 1'b0, 1'b0);
        bus.mode = 1'b0;
        tick();
        chk_state("mode_sw", 4'b0001, 1'b0, 1'b0);
        tick();
        chk_state("after_sw", 4'b0010, 1'b0, 1'b0);
        reset        = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'b1111;
        tick();
        chk_state("rst_over_load", 4'b0001, 1'b0, 1'b0);
        reset    = 1'b0;
        bus.load = 1'b0;
        bus.en   = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
